// File: rtl/rle_block_sequencer_if.sv
// Handshake and memory-write bundle between rle_block_sequencer and its surroundings.
// master = upstream/packer side that drives rows and words; slave = the sequencer.
interface rle_block_sequencer_if #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned WORD_W = 112
);
  logic              start;
  logic [11:0]       num_blocks;
  logic              row_valid;
  logic              row_ready;
  logic              rle_en;
  logic              blk_start;
  logic              pack_flush;
  logic              word_valid;
  logic [WORD_W-1:0] word_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              busy;
  logic              done;
  logic              mem_full;
  logic [ADDR_W:0]   words_written;

  modport master (
    output start, num_blocks, row_valid, word_valid, word_data,
    input  row_ready, rle_en, blk_start, pack_flush, mem_we, mem_addr, mem_wdata,
    input  busy, done, mem_full, words_written
  );

  modport slave (
    input  start, num_blocks, row_valid, word_valid, word_data,
    output row_ready, rle_en, blk_start, pack_flush, mem_we, mem_addr, mem_wdata,
    output busy, done, mem_full, words_written
  );
endinterface

// File: rtl/rle_block_sequencer.sv
// Frame sequencer for the 8x8-block RLE datapath: paces rows, flushes the packer per block
// and writes packed words to SRAM. Define RLE_SEQ_ADDR_WRAP_EN to wrap instead of stalling.
module rle_block_sequencer #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned WORD_W = 112
) (
  input logic                  clk,
  input logic                  reset,
  rle_block_sequencer_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StRun, StFlush, StDrain, StStall} state_e;

  localparam logic [ADDR_W-1:0] AddrLast = '1;

  state_e            state_q, state_d;
  logic [11:0]       blk_cnt_q, blk_cnt_d;
  logic [11:0]       nblk_q, nblk_d;
  logic [2:0]        row_cnt_q, row_cnt_d;
  logic              drain_q, drain_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   ww_q, ww_d;
  logic              full_q, full_d;
  logic              done_q, done_d;

  logic row_ready, rle_en, mem_we;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      blk_cnt_q <= '0;
      nblk_q    <= 12'd1;
      row_cnt_q <= '0;
      drain_q   <= 1'b0;
      addr_q    <= '0;
      ww_q      <= '0;
      full_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      blk_cnt_q <= blk_cnt_d;
      nblk_q    <= nblk_d;
      row_cnt_q <= row_cnt_d;
      drain_q   <= drain_d;
      addr_q    <= addr_d;
      ww_q      <= ww_d;
      full_q    <= full_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    blk_cnt_d = blk_cnt_q;
    nblk_d    = nblk_q;
    row_cnt_d = row_cnt_q;
    drain_d   = drain_q;
    addr_d    = addr_q;
    ww_d      = ww_q;
    full_d    = full_q;
    done_d    = 1'b0;

    row_ready = (state_q == StRun) && !full_q;
    rle_en    = row_ready && bus.row_valid;
    // IDLE and STALL never write; a start coinciding with word_valid drops the word.
    mem_we    = (state_q != StIdle) && (state_q != StStall) && bus.word_valid && !full_q;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d   = StRun;
          blk_cnt_d = '0;
          row_cnt_d = '0;
          ww_d      = '0;
          nblk_d    = (bus.num_blocks == 12'd0) ? 12'd1 : bus.num_blocks;
        end
      end
      StRun: begin
        if (rle_en) begin
          row_cnt_d = row_cnt_q + 3'd1;
          if (row_cnt_q == 3'd7) state_d = StFlush;
        end
      end
      StFlush: begin
        state_d = StDrain;
        drain_d = 1'b0;
      end
      StDrain: begin
        drain_d = 1'b1;
        if (drain_q) begin
          blk_cnt_d = blk_cnt_q + 12'd1;
          if (blk_cnt_q + 12'd1 == nblk_q) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d = StRun;
          end
        end
      end
      StStall: ;
      default: state_d = StIdle;
    endcase

    if (mem_we) begin
      ww_d = ww_q + 1'b1;
      if (addr_q == AddrLast) begin
`ifdef RLE_SEQ_ADDR_WRAP_EN
        addr_d = '0;
`else
        // Hold the address; the stall overrides whatever the frame FSM wanted.
        full_d  = 1'b1;
        state_d = StStall;
`endif
      end else begin
        addr_d = addr_q + 1'b1;
      end
    end
  end

  assign bus.row_ready     = row_ready;
  assign bus.rle_en        = rle_en;
  assign bus.blk_start     = rle_en && (row_cnt_q == 3'd0);
  assign bus.pack_flush    = (state_q == StFlush);
  assign bus.mem_we        = mem_we;
  assign bus.mem_addr      = addr_q;
  assign bus.mem_wdata     = mem_we ? bus.word_data : '0;
  assign bus.busy          = (state_q != StIdle);
  assign bus.done          = done_q;
  assign bus.mem_full      = full_q;
  assign bus.words_written = ww_q;

endmodule

// File: tb/tb_rle_block_sequencer.sv
// Self-checking bench for rle_block_sequencer: a per-cycle vector table for a single-block
// frame with writes, plus hand sequences for streaming, num_blocks=0, mid-frame reset and full.
module tb_rle_block_sequencer;
  localparam int unsigned ADDR_W = 14;
  localparam int unsigned WORD_W = 112;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rle_block_sequencer_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) bus ();

  rle_block_sequencer #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ctl = {row_ready, rle_en, blk_start, pack_flush, mem_we, busy, done, mem_full}
  typedef struct {
    logic        start;
    logic [11:0] nb;
    logic        rv;
    logic        wv;
    logic [7:0]  wd;
    logic [7:0]  exp_ctl;
    logic [13:0] exp_addr;
    logic [14:0] exp_ww;
    logic [7:0]  exp_wd;
  } vec_t;

  vec_t vecs[14];

  function automatic logic [7:0] ctl();
    return {bus.row_ready, bus.rle_en, bus.blk_start, bus.pack_flush,
            bus.mem_we, bus.busy, bus.done, bus.mem_full};
  endfunction

  initial begin
    int blk_n, run, acc, cnt;
    bit done_seen;
    int runs[$];

    // Single block, num_blocks=1; words 1..5 on the first five rows.
    vecs[0]  = '{1'b1, 12'd1, 1'b1, 1'b1, 8'hAA, 8'b0000_0000, 14'd0, 15'd0, 8'h00};
    vecs[1]  = '{1'b0, 12'd0, 1'b1, 1'b1, 8'h01, 8'b1110_1100, 14'd0, 15'd0, 8'h01};
    vecs[2]  = '{1'b0, 12'd0, 1'b1, 1'b1, 8'h02, 8'b1100_1100, 14'd1, 15'd1, 8'h02};
    vecs[3]  = '{1'b0, 12'd0, 1'b1, 1'b1, 8'h03, 8'b1100_1100, 14'd2, 15'd2, 8'h03};
    vecs[4]  = '{1'b0, 12'd0, 1'b1, 1'b1, 8'h04, 8'b1100_1100, 14'd3, 15'd3, 8'h04};
    vecs[5]  = '{1'b0, 12'd0, 1'b1, 1'b1, 8'h05, 8'b1100_1100, 14'd4, 15'd4, 8'h05};
    vecs[6]  = '{1'b0, 12'd0, 1'b1, 1'b0, 8'h00, 8'b1100_0100, 14'd5, 15'd5, 8'h00};
    vecs[7]  = '{1'b0, 12'd0, 1'b1, 1'b0, 8'h00, 8'b1100_0100, 14'd5, 15'd5, 8'h00};
    vecs[8]  = '{1'b0, 12'd0, 1'b1, 1'b0, 8'h00, 8'b1100_0100, 14'd5, 15'd5, 8'h00};
    vecs[9]  = '{1'b0, 12'd0, 1'b1, 1'b0, 8'h00, 8'b0001_0100, 14'd5, 15'd5, 8'h00};
    vecs[10] = '{1'b0, 12'd0, 1'b1, 1'b0, 8'h00, 8'b0000_0100, 14'd5, 15'd5, 8'h00};
    vecs[11] = '{1'b0, 12'd0, 1'b1, 1'b0, 8'h00, 8'b0000_0100, 14'd5, 15'd5, 8'h00};
    vecs[12] = '{1'b0, 12'd0, 1'b1, 1'b1, 8'h09, 8'b0000_0010, 14'd5, 15'd5, 8'h00};
    vecs[13] = '{1'b0, 12'd0, 1'b0, 1'b0, 8'h00, 8'b0000_0000, 14'd5, 15'd5, 8'h00};

    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.num_blocks = 12'd0;
    bus.row_valid  = 1'b1;
    bus.word_valid = 1'b1;
    bus.word_data  = WORD_W'(32'h1234);
    #4;
    check("reset_ctl", ctl(), 8'h00);
    check("reset_addr", bus.mem_addr, 0);
    check("reset_wdata", bus.mem_wdata, 0);
    check("reset_ww", bus.words_written, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      bus.start      = vecs[i].start;
      bus.num_blocks = vecs[i].nb;
      bus.row_valid  = vecs[i].rv;
      bus.word_valid = vecs[i].wv;
      bus.word_data  = WORD_W'(vecs[i].wd);
      #4;
      check($sformatf("vec%0d_ctl", i), ctl(), vecs[i].exp_ctl);
      check($sformatf("vec%0d_addr", i), bus.mem_addr, vecs[i].exp_addr);
      check($sformatf("vec%0d_ww", i), bus.words_written, vecs[i].exp_ww);
      check($sformatf("vec%0d_wdata", i), bus.mem_wdata, vecs[i].exp_wd);
      step();
    end

    // Three-block continuous stream.
    bus.start = 1'b1; bus.num_blocks = 12'd3; bus.row_valid = 1'b1; bus.word_valid = 1'b0;
    step();
    bus.start = 1'b0;
    blk_n = 0; run = 0; done_seen = 0;
    for (int c = 0; c < 100 && !done_seen; c++) begin
      #4;
      if (bus.blk_start) blk_n++;
      if (bus.busy && !bus.row_ready) run++;
      else if (run > 0) begin runs.push_back(run); run = 0; end
      if (bus.done) done_seen = 1;
      else step();
    end
    check("stream_done", done_seen, 1);
    check("stream_blk_starts", blk_n, 3);
    check("stream_gap_count", runs.size(), 3);
    foreach (runs[k]) check($sformatf("stream_gap%0d", k), runs[k], 3);
    check("stream_ww_cleared", bus.words_written, 0);
    check("stream_addr_kept", bus.mem_addr, 5);
    step();

    // num_blocks=0 behaves as one block: done 12 cycles after the start cycle.
    bus.start = 1'b1; bus.num_blocks = 12'd0;
    step();
    bus.start = 1'b0;
    cnt = 1; blk_n = 0; done_seen = 0;
    for (int c = 0; c < 50 && !done_seen; c++) begin
      #4;
      if (bus.blk_start) blk_n++;
      if (bus.done) done_seen = 1;
      else begin step(); cnt++; end
    end
    check("nb0_done_seen", done_seen, 1);
    check("nb0_done_latency", cnt, 12);
    check("nb0_blk_starts", blk_n, 1);
    step();

    // Mid-frame reset at block 1 row 4, with words being written throughout.
    bus.start = 1'b1; bus.num_blocks = 12'd3; bus.word_valid = 1'b1; bus.word_data = WORD_W'(8'h3C);
    step();
    bus.start = 1'b0;
    acc = 0; done_seen = 0;
    for (int c = 0; c < 60 && acc < 12; c++) begin
      #4;
      if (bus.rle_en) acc++;
      if (bus.done) done_seen = 1;
      step();
    end
    check("mid_rows_reached", acc, 12);
    check("mid_no_done", done_seen, 0);
    #2 reset = 1'b1;
    #1;
    check("mid_reset_ctl", ctl(), 8'h00);
    check("mid_reset_addr", bus.mem_addr, 0);
    check("mid_reset_wdata", bus.mem_wdata, 0);
    check("mid_reset_ww", bus.words_written, 0);
    step();
    reset = 1'b0;
    bus.start = 1'b1; bus.num_blocks = 12'd1; bus.word_data = WORD_W'(8'h07);
    step();
    bus.start = 1'b0;
    #4;
    check("restart_blk_start", bus.blk_start, 1);
    check("restart_we", bus.mem_we, 1);
    check("restart_addr", bus.mem_addr, 0);
    check("restart_wdata", bus.mem_wdata, 7);

    // Fill the whole address space.
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.start = 1'b1; bus.num_blocks = 12'd4095; bus.row_valid = 1'b0; bus.word_valid = 1'b0;
    step();
    bus.start = 1'b0;
    bus.word_valid = 1'b1;
    for (int i = 0; i < 16384; i++) begin
      bus.word_data = WORD_W'(i);
      #4;
      if (i == 0) check("full_first_addr", bus.mem_addr, 0);
      if (i == 16383) begin
        check("full_last_addr", bus.mem_addr, 14'h3FFF);
        check("full_last_we", bus.mem_we, 1);
      end
      step();
    end
    bus.row_valid = 1'b1;
    bus.word_data = WORD_W'(32'd16384);
    #4;
    check("full_ww", bus.words_written, 16384);
`ifdef RLE_SEQ_ADDR_WRAP_EN
    check("wrap_we", bus.mem_we, 1);
    check("wrap_addr", bus.mem_addr, 0);
    check("wrap_full", bus.mem_full, 0);
`else
    check("stall_full", bus.mem_full, 1);
    check("stall_row_ready", bus.row_ready, 0);
    check("stall_we", bus.mem_we, 0);
    check("stall_busy", bus.busy, 1);
`endif
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
